// File: rtl/sys_timer_if.sv
// Wishbone slave bus bundle for sys_timer: 4-bit register address, 8-bit data,
// single-cycle handshake.
interface sys_timer_if;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sys_timer.sv
// System timer: fractional CPU clock-enable, 1 us / 1 ms strobes and NCH
// periodic millisecond interrupt channels behind an 8-bit Wishbone slave.
module sys_timer #(
  parameter int unsigned REFCLK = 100000000,
  parameter int unsigned CPUCLK = 2500000,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned NCH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  sys_timer_if.slave     wb,
  input  logic [NCH-1:0] irq_ack,
  output logic           ena_f2,
  output logic           ena_us,
  output logic           ena_ms,
  output logic [NCH-1:0] irq
);

  // INC is computed in 64 bits so CPUCLK * 2^ACC_W cannot overflow.
  localparam logic [63:0] INC_FULL = ({32'd0, CPUCLK} << ACC_W) / {32'd0, REFCLK};
  localparam logic [ACC_W-1:0] INC = INC_FULL[ACC_W-1:0];

  localparam int unsigned US_DIV = REFCLK / 1000000;
  localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [US_W-1:0] US_TC = US_W'(US_DIV - 1);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W:0]   acc_sum_s;
  logic [US_W-1:0]  us_cnt_r;
  logic [9:0]       ms_cnt_r;
  logic             us_tc_s;
  logic             ms_tc_s;

  logic [NCH-1:0]   ctrl_r;
  logic [NCH-1:0]   flag_r;
  logic [15:0]      per_r [NCH];
  logic [15:0]      cnt_r [NCH];

  logic             wr_s;
  logic             ctrl_wr_s;
  logic             status_wr_s;
  logic [NCH-1:0]   en_rise_s;
  logic [NCH-1:0]   cnt_zero_s;
  logic [NCH-1:0]   set_s;
  logic [NCH-1:0]   clr_s;
  logic [NCH-1:0]   flag_nxt_s;
  logic [7:0]       rd_s;

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, INC};
  assign us_tc_s   = (us_cnt_r == US_TC);
  assign ms_tc_s   = us_tc_s && (ms_cnt_r == 10'd999);

  // Phase accumulator; its carry is the CPU clock-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= {ACC_W{1'b0}};
      ena_f2 <= 1'b0;
    end else begin
      acc_r  <= acc_sum_s[ACC_W-1:0];
      ena_f2 <= acc_sum_s[ACC_W];
    end
  end

  // Microsecond and millisecond dividers; ena_ms coincides with the 1000th ena_us.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt_r <= {US_W{1'b0}};
      ms_cnt_r <= 10'd0;
      ena_us   <= 1'b0;
      ena_ms   <= 1'b0;
    end else begin
      ena_us <= us_tc_s;
      ena_ms <= ms_tc_s;
      if (us_tc_s) begin
        us_cnt_r <= {US_W{1'b0}};
        ms_cnt_r <= (ms_cnt_r == 10'd999) ? 10'd0 : ms_cnt_r + 10'd1;
      end else begin
        us_cnt_r <= us_cnt_r + US_W'(1);
      end
    end
  end

  assign wr_s        = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
  assign ctrl_wr_s   = wr_s && (wb.wb_adr_i == 4'd0);
  assign status_wr_s = wr_s && (wb.wb_adr_i == 4'd1);

  // Per-channel control terms; a flag set beats a simultaneous clear.
  always_comb begin
    en_rise_s  = {NCH{1'b0}};
    cnt_zero_s = {NCH{1'b0}};
    clr_s      = irq_ack;
    if (ctrl_wr_s) begin
      en_rise_s = wb.wb_dat_i[NCH-1:0] & ~ctrl_r;
    end else begin
      en_rise_s = {NCH{1'b0}};
    end
    if (status_wr_s) begin
      clr_s = irq_ack | wb.wb_dat_i[NCH-1:0];
    end else begin
      clr_s = irq_ack;
    end
    for (int i = 0; i < NCH; i++) begin
      cnt_zero_s[i] = (cnt_r[i] == 16'd0);
    end
    set_s      = ctrl_r & {NCH{ena_ms}} & cnt_zero_s;
    flag_nxt_s = set_s | (flag_r & ~clr_s);
  end

  // Control register, flags and the registered interrupt lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= {NCH{1'b0}};
      flag_r <= {NCH{1'b0}};
      irq    <= {NCH{1'b0}};
    end else begin
      if (ctrl_wr_s) begin
        ctrl_r <= wb.wb_dat_i[NCH-1:0];
      end
      flag_r <= flag_nxt_s;
      irq    <= flag_r;
    end
  end

  // Period registers and down-counters; enabling a channel reloads its counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        per_r[i] <= 16'd0;
        cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_s && (wb.wb_adr_i == 4'(2 + 2 * i))) begin
          per_r[i][7:0] <= wb.wb_dat_i;
        end
        if (wr_s && (wb.wb_adr_i == 4'(3 + 2 * i))) begin
          per_r[i][15:8] <= wb.wb_dat_i;
        end
        if (en_rise_s[i]) begin
          cnt_r[i] <= per_r[i];
        end else if (ctrl_r[i] && ena_ms) begin
          cnt_r[i] <= cnt_zero_s[i] ? per_r[i] : cnt_r[i] - 16'd1;
        end
      end
    end
  end

  // Combinational read mux of the current register contents.
  always_comb begin
    rd_s = 8'd0;
    case (wb.wb_adr_i)
      4'd0: rd_s[NCH-1:0] = ctrl_r;
      4'd1: rd_s[NCH-1:0] = flag_r;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (wb.wb_adr_i == 4'(2 + 2 * i)) begin
            rd_s = per_r[i][7:0];
          end else if (wb.wb_adr_i == 4'(3 + 2 * i)) begin
            rd_s = per_r[i][15:8];
          end else begin
            rd_s = rd_s;
          end
        end
      end
    endcase
  end

  assign wb.wb_dat_o = rd_s;
  assign wb.wb_ack_o = wb.wb_cyc_i & wb.wb_stb_i;

endmodule

// File: tb/tb_sys_timer.sv
// Directed bench for sys_timer, scaled to REFCLK = 2 MHz (1 us = 2 clk,
// 1 ms = 2000 clk) with the default 40:1 ratio for the CPU enable.
module tb_sys_timer;
  logic       clk;
  logic       rst;
  logic [1:0] irq_ack;
  logic       ena_f2;
  logic       ena_us;
  logic       ena_ms;
  logic [1:0] irq;

  int n_chk;
  int n_pass;

  sys_timer_if bus ();

  sys_timer #(
    .REFCLK(2000000),
    .CPUCLK(50000),
    .ACC_W (32),
    .NCH   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wb     (bus),
    .irq_ack(irq_ack),
    .ena_f2 (ena_f2),
    .ena_us (ena_us),
    .ena_ms (ena_ms),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    step();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.wb_adr_i = a;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    #1;
    chk(tag, 32'(bus.wb_dat_o), 32'(exp));
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic wait_ms();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 2100 && !got; k++) begin
      step();
      if (ena_ms) got = 1'b1;
    end
    chk("wait_ms_bound", 32'(got), 32'd1);
  endtask

  initial begin
    int f2_cnt, us_cnt, ms_cnt, adj, first_f2, first_us, first_ms, second_ms;
    logic prev_f2;
    logic strobe_seen;

    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    irq_ack = 2'b00;
    bus.wb_adr_i = 4'd0;
    bus.wb_dat_i = 8'd0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;

    // Reset state
    #2;
    chk("rst_ena_f2", 32'(ena_f2), 32'd0);
    chk("rst_ena_us", 32'(ena_us), 32'd0);
    chk("rst_ena_ms", 32'(ena_ms), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("idle_ack", 32'(bus.wb_ack_o), 32'd0);
    #18;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    #1;
    chk("ack_comb", 32'(bus.wb_ack_o), 32'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    rd_chk("rst_ctrl", 4'd0, 8'h00);
    rst = 1'b0;

    // Strobe timing over 40000 clocks
    f2_cnt = 0; us_cnt = 0; ms_cnt = 0; adj = 0;
    first_f2 = 0; first_us = 0; first_ms = 0; second_ms = 0;
    prev_f2 = 1'b0;
    for (int e = 1; e <= 40000; e++) begin
      step();
      if (ena_f2) begin
        f2_cnt++;
        if (prev_f2) adj++;
        if (first_f2 == 0) first_f2 = e;
      end
      prev_f2 = ena_f2;
      if (ena_us) begin
        us_cnt++;
        if (first_us == 0) first_us = e;
      end
      if (ena_ms) begin
        ms_cnt++;
        if (first_ms == 0) first_ms = e;
        else if (second_ms == 0) second_ms = e;
      end
    end
    chk("f2_count_in_range", 32'(f2_cnt >= 999 && f2_cnt <= 1001), 32'd1);
    chk("f2_adjacent", 32'(adj), 32'd0);
    chk("f2_first", 32'(first_f2), 32'd41);
    chk("us_first", 32'(first_us), 32'd2);
    chk("us_count", 32'(us_cnt), 32'd20000);
    chk("ms_first", 32'(first_ms), 32'd2000);
    chk("ms_period", 32'(second_ms - first_ms), 32'd2000);
    chk("ms_count", 32'(ms_cnt), 32'd20);

    // Channel 0, period 4 -> flag every 5 ms
    wait_ms();
    wr(4'd2, 8'd4);
    wr(4'd3, 8'd0);
    wr(4'd0, 8'h01);
    repeat (5) wait_ms();
    chk("ch0_no_early_irq", 32'(irq), 32'd0);
    rd_chk("ch0_status_pre", 4'd1, 8'h00);
    step();
    rd_chk("ch0_status_set", 4'd1, 8'h01);
    chk("ch0_irq_lag", 32'(irq), 32'd0);
    step();
    chk("ch0_irq_rise", 32'(irq), 32'd1);
    wr(4'd1, 8'h01);
    chk("ch0_irq_clear_lag", 32'(irq), 32'd1);
    step();
    chk("ch0_irq_cleared", 32'(irq), 32'd0);

    // Clear collides with set: set wins, then irq_ack clears
    repeat (5) wait_ms();
    wr(4'd1, 8'h01);
    rd_chk("ch0_set_wins", 4'd1, 8'h01);
    irq_ack = 2'b01;
    step();
    irq_ack = 2'b00;
    chk("ch0_irq_stays", 32'(irq), 32'd1);
    step();
    chk("ch0_irq_acked", 32'(irq), 32'd0);
    rd_chk("ch0_status_acked", 4'd1, 8'h00);

    // Channel 1, period 0 -> flag every ms
    wait_ms();
    wr(4'd4, 8'd0);
    wr(4'd0, 8'h02);
    wait_ms();
    step();
    step();
    chk("ch1_set_a", 32'(irq), 32'd2);
    wr(4'd1, 8'h02);
    step();
    chk("ch1_cleared", 32'(irq), 32'd0);
    wait_ms();
    step();
    step();
    chk("ch1_set_b", 32'(irq), 32'd2);
    wr(4'd0, 8'h00);
    wait_ms();
    step();
    step();
    chk("ch1_retained", 32'(irq), 32'd2);
    rd_chk("ch1_status_retained", 4'd1, 8'h02);
    wr(4'd1, 8'h02);
    wait_ms();
    step();
    step();
    chk("ch1_no_set_disabled", 32'(irq), 32'd0);
    rd_chk("unmapped_15", 4'd15, 8'h00);
    rd_chk("ctrl_readback", 4'd0, 8'h00);
    rd_chk("perl0_readback", 4'd2, 8'h04);

    // Mid-operation reset
    wr(4'd0, 8'h02);
    wait_ms();
    step();
    step();
    chk("pre_reset_irq", 32'(irq), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_irq", 32'(irq), 32'd0);
    chk("async_rst_strobes", 32'({ena_f2, ena_us, ena_ms}), 32'd0);
    rd_chk("async_rst_status", 4'd1, 8'h00);
    rd_chk("async_rst_perl0", 4'd2, 8'h00);
    strobe_seen = 1'b0;
    repeat (3) begin
      step();
      if (ena_f2 || ena_us || ena_ms || (irq != 2'b00)) strobe_seen = 1'b1;
    end
    chk("no_strobe_in_rst", 32'(strobe_seen), 32'd0);
    #3;
    rst = 1'b0;
    first_us = 0;
    first_ms = 0;
    for (int e = 1; e <= 2100 && first_ms == 0; e++) begin
      step();
      if (ena_us && first_us == 0) first_us = e;
      if (ena_ms) first_ms = e;
    end
    chk("post_rst_us_first", 32'(first_us), 32'd2);
    chk("post_rst_ms_first", 32'(first_ms), 32'd2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
